// File: rtl/pattern_tx_pkg.sv
// Shared types and constants for the pattern serializer.
package pattern_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [3:0] MAX_LEN = 4'd8;

endpackage

// File: rtl/flex_counter.sv
// 4-bit loadable down-counter; tc flags the final cycle of a phase (count == 1).
module flex_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       tc
);

  logic [3:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign tc = (count == 4'd1);

endmodule

// File: rtl/pattern_tx.sv
// Serializes an 8-bit pattern MSB first with optional repetition and zero gaps.
// The repetition-count port is named repeats because repeat is a reserved word.
module pattern_tx
  import pattern_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] pattern,
  input  logic [3:0] length,
  input  logic [3:0] repeats,
  input  logic [3:0] gap,
  input  logic       abort,
  output logic       o,
  output logic       o_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_t     st, st_n;
  logic [7:0] pat_r, sreg, sreg_n;
  logic [3:0] len_r, gap_r, rep_r, rep_n;
  logic       o_n, valid_n, done_n, err_n, cap;
  logic       cnt_load, cnt_en, cnt_tc;
  logic [3:0] cnt_val;

  flex_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  // rep_r counts remaining repetitions; 0 means continuous and is never decremented.
  always_comb begin
    st_n     = st;
    sreg_n   = sreg;
    rep_n    = rep_r;
    o_n      = 1'b0;
    valid_n  = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    cap      = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = len_r;
    case (st)
      IDLE: begin
        if (start && !abort) begin
          if (length != 4'd0 && length <= MAX_LEN) begin
            cap      = 1'b1;
            st_n     = SHIFT;
            cnt_load = 1'b1;
            cnt_val  = length;
            rep_n    = repeats;
            sreg_n   = {pattern[6:0], 1'b0};
            o_n      = pattern[7];
            valid_n  = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (!cnt_tc) begin
          cnt_en  = 1'b1;
          o_n     = sreg[7];
          valid_n = 1'b1;
          sreg_n  = {sreg[6:0], 1'b0};
        end else if (rep_r == 4'd1) begin
          st_n   = FINISH;
          done_n = 1'b1;
        end else begin
          if (rep_r != 4'd0) rep_n = rep_r - 4'd1;
          cnt_load = 1'b1;
          if (gap_r != 4'd0) begin
            st_n    = GAP;
            cnt_val = gap_r;
          end else begin
            o_n     = pat_r[7];
            valid_n = 1'b1;
            sreg_n  = {pat_r[6:0], 1'b0};
          end
        end
      end
      GAP: begin
        if (!cnt_tc) begin
          cnt_en = 1'b1;
        end else begin
          st_n     = SHIFT;
          cnt_load = 1'b1;
          o_n      = pat_r[7];
          valid_n  = 1'b1;
          sreg_n   = {pat_r[6:0], 1'b0};
        end
      end
      FINISH:  st_n = IDLE;
      default: st_n = IDLE;
    endcase
    if (abort && st != IDLE) begin
      st_n     = IDLE;
      o_n      = 1'b0;
      valid_n  = 1'b0;
      done_n   = 1'b0;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      sreg    <= 8'd0;
      pat_r   <= 8'd0;
      len_r   <= 4'd0;
      gap_r   <= 4'd0;
      rep_r   <= 4'd0;
      o       <= 1'b0;
      o_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      st      <= st_n;
      sreg    <= sreg_n;
      rep_r   <= rep_n;
      o       <= o_n;
      o_valid <= valid_n;
      busy    <= (st_n != IDLE);
      done    <= done_n;
      err     <= err_n;
      if (cap) begin
        pat_r <= pattern;
        len_r <= length;
        gap_r <= gap;
      end
    end
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Randomized self-checking bench for pattern_tx against a per-cycle output reference.
module tb_pattern_tx;

  typedef logic [4:0] obs_t;  // {o, o_valid, busy, done, err}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = 8'd0;
  logic [3:0] length = 4'd0;
  logic [3:0] repeats = 4'd0;
  logic [3:0] gap = 4'd0;
  logic       o, o_valid, busy, done, err;

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  pattern_tx dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .length  (length),
    .repeats (repeats),
    .gap     (gap),
    .abort   (abort),
    .o       (o),
    .o_valid (o_valid),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  task automatic check_eq(input string tag, input obs_t got, input obs_t expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b (o,valid,busy,done,err)", tag, got, expv);
    end
  endtask

  function automatic obs_t outs();
    return {o, o_valid, busy, done, err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs from cycle 1 after acceptance through the following idle cycle.
  function automatic void model_tx(input logic [7:0] p, input int len, input int rep, input int g);
    for (int r = 0; r < rep; r++) begin
      for (int i = 0; i < len; i++) exp_q.push_back({p[7-i], 1'b1, 1'b1, 2'b00});
      if (r < rep - 1)
        for (int k = 0; k < g; k++) exp_q.push_back(5'b00100);
    end
    exp_q.push_back(5'b00110);
    exp_q.push_back(5'b00000);
  endfunction

  task automatic launch(input logic [7:0] p, input int len, input int rep, input int g);
    pattern = p;
    length  = 4'(len);
    repeats = 4'(rep);
    gap     = 4'(g);
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic drain(input string tag, input bit noise);
    while (exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      check_eq(tag, outs(), e);
      if (noise && exp_q.size() > 2) begin
        pattern = 8'($urandom);
        length  = 4'($urandom);
        repeats = 4'($urandom);
        gap     = 4'($urandom);
        start   = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      step();
    end
  endtask

  task automatic run_tx(input string tag, input logic [7:0] p, input int len, input int rep,
                        input int g, input bit noise);
    model_tx(p, len, rep, g);
    launch(p, len, rep, g);
    drain(tag, noise);
  endtask

  // Continuous mode: bit position follows a fixed period of len + gap cycles.
  task automatic run_cont(input string tag, input logic [7:0] p, input int len, input int g,
                          input int ncyc);
    int period;
    period = len + g;
    launch(p, len, 0, g);
    for (int t = 1; t <= ncyc; t++) begin
      int pos;
      pos = (t - 1) % period;
      if (pos < len) check_eq(tag, outs(), {p[7-pos], 1'b1, 1'b1, 2'b00});
      else           check_eq(tag, outs(), 5'b00100);
      pattern = 8'($urandom);
      length  = 4'($urandom);
      if (t == ncyc) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    check_eq({tag, "_abort"}, outs(), 5'b00000);
    step();
    check_eq({tag, "_after"}, outs(), 5'b00000);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int na;
    step();
    step();
    check_eq("reset", outs(), 5'b00000);
    rst = 1'b0;
    step();
    check_eq("idle", outs(), 5'b00000);

    run_tx("case1", 8'hD0, 4, 1, 0, 1'b0);
    run_tx("case2", 8'hA5, 8, 2, 3, 1'b0);
    run_tx("case2_busy_start", 8'hA5, 8, 2, 3, 1'b1);
    run_cont("case3", 8'hC0, 2, 0, 7);
    run_tx("len1_gap15", 8'h80, 1, 2, 15, 1'b0);

    length = 4'd0; start = 1'b1; step();
    check_eq("err_len0", outs(), 5'b00001);
    start = 1'b0; step();
    check_eq("err_len0_clear", outs(), 5'b00000);
    length = 4'd9; start = 1'b1; step();
    check_eq("err_len9", outs(), 5'b00001);
    start = 1'b0; step();
    check_eq("err_len9_clear", outs(), 5'b00000);
    length = 4'd15; start = 1'b1; step();
    check_eq("err_len15", outs(), 5'b00001);
    start = 1'b0; step();
    check_eq("err_len15_clear", outs(), 5'b00000);

    abort = 1'b1; start = 1'b1; length = 4'd4; repeats = 4'd1; pattern = 8'hFF; step();
    check_eq("abort_wins_valid", outs(), 5'b00000);
    length = 4'd0; step();
    check_eq("abort_wins_err", outs(), 5'b00000);
    abort = 1'b0; start = 1'b0; step();
    check_eq("abort_wins_idle", outs(), 5'b00000);

    launch(8'h5A, 8, 1, 0);
    check_eq("rst_bit1", outs(), 5'b01100);
    step();
    check_eq("rst_bit2", outs(), 5'b11100);
    step();
    check_eq("rst_bit3", outs(), 5'b01100);
    #2 rst = 1'b1;
    #1 check_eq("rst_async", outs(), 5'b00000);
    step();
    step();
    rst = 1'b0;
    run_tx("after_rst", 8'hC3, 8, 1, 0, 1'b0);

    // start held high through FINISH chains a second transmission after one idle cycle
    model_tx(8'hB4, 6, 1, 0);
    na = exp_q.size();
    model_tx(8'h6C, 3, 2, 1);
    pattern = 8'hB4; length = 4'd6; repeats = 4'd1; gap = 4'd0;
    start = 1'b1;
    step();
    pattern = 8'h6C; length = 4'd3; repeats = 4'd2; gap = 4'd1;
    for (int k = 0; exp_q.size() > 0; k++) begin
      obs_t e;
      e = exp_q.pop_front();
      check_eq("held_start", outs(), e);
      if (k >= na) start = 1'b0;
      step();
    end

    for (int n = 0; n < 25; n++) begin
      run_tx("rand_tx", 8'($urandom), int'($urandom_range(1, 8)), int'($urandom_range(1, 3)),
             int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 4; n++) begin
      run_cont("rand_cont", 8'($urandom), int'($urandom_range(1, 8)), int'($urandom_range(0, 3)),
               int'($urandom_range(5, 30)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request to begin a transmission, sampled only in IDLE.
REQ-004 SHALL have port pattern, input, 8, word to serialize, MSB (bit 7) first.
REQ-005 SHALL have port length, input, 4, number of pattern bits to send, legal 1..8.
REQ-006 SHALL have port repeat, input, 4, number of pattern repetitions; 0 means continuous until abort.
REQ-007 SHALL have port gap, input, 4, count of zero-valued idle bits inserted between repetitions.
REQ-008 SHALL have port abort, input, 1, terminates the transmission immediately.
REQ-009 SHALL have port o, output, 1, serial data bit.
REQ-010 SHALL have port o_valid, output, 1, high when o carries a pattern bit; low for gap bits and when idle.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse on normal completion.
REQ-013 SHALL have port err, output, 1, one-cycle pulse when start is rejected.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, GAP and FINISH.
REQ-015 SHALL drive o, o_valid, busy, done and err from registers (Moore-style); no input-to-output combinational path.
REQ-016 In IDLE, start=1 with length in 1..8 SHALL capture pattern, length, repeat and gap, then enter SHIFT.
REQ-017 Input changes after capture SHALL be ignored until the next IDLE.
REQ-018 For a start accepted at edge N, the first bit SHALL appear on o with o_valid=1 in the cycle after edge N.
REQ-019 SHIFT SHALL present one bit per cycle, pattern[7] down to pattern[8-length].
REQ-020 After the last bit, SHIFT SHALL go to FINISH when the repetition count is exhausted.
REQ-021 Otherwise, after the last bit, SHIFT SHALL go to GAP when gap>0 and back to SHIFT when gap=0, so repetitions run back-to-back.
REQ-022 GAP SHALL last exactly gap cycles with o=0 and o_valid=0, then return to SHIFT.
REQ-023 A repeat value of R>0 SHALL produce exactly R repetitions.
REQ-024 A repeat value of 0 SHALL repeat the pattern indefinitely until abort.
REQ-025 FINISH SHALL last one cycle with done=1, busy=1 and o=0, then return to IDLE.
REQ-026 In IDLE, start with length=0 or length>8 SHALL pulse err=1 for one cycle and remain in IDLE.
REQ-027 Start while busy SHALL be ignored, with no err pulse.
REQ-028 Abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge, with o=0, o_valid=0 and no done pulse.
REQ-029 When abort and start are both high in IDLE, abort SHALL win: no capture and no err pulse.
REQ-030 Start sampled high in the IDLE cycle immediately after FINISH SHALL be accepted.
REQ-031 The bit and gap counters SHALL be 4 bits wide, with no wrap beyond 8 bits or 15 gap cycles.
REQ-032 The repetition counter SHALL be 4 bits wide and SHALL hold at 0 in continuous mode.

Reset
REQ-033 rst=1 SHALL force state=IDLE and o, o_valid, busy, done, err=0 regardless of clk.
REQ-034 Reset asserted mid-transmission SHALL discard all captured inputs and counts.
REQ-035 After reset deasserts, operation SHALL resume on the first clk edge.

Structure
REQ-036 Package pattern_tx_pkg SHALL hold the state enum and constant MAX_LEN=8.
REQ-037 Bit and gap counting SHALL use one instance of the existing flex_counter sub-module, reloaded per phase.

Verification
REQ-038 Case 1: pattern=8'hD0, length=4, repeat=1, gap=0 -> o=1,1,0,1 with o_valid=1 over cycles 1-4, then done=1 at cycle 5 and busy=0 at cycle 6.
REQ-039 Case 2: pattern=8'hA5, length=8, repeat=2, gap=3 -> 10100101, then three cycles of o=0 with o_valid=0, then 10100101, then a done pulse.
REQ-040 Case 3: repeat=0, pattern=8'hC0, length=2 -> 1,1 repeating; abort at cycle 7 -> busy=0 at cycle 8 with no done pulse.
REQ-041 Case 4: start with length=0 and then length=9 -> err pulses once per request, busy stays 0; start during busy -> no effect.
REQ-042 Case 5: rst pulsed in SHIFT at bit 3 -> all outputs 0 immediately; a new start after release transmits from bit 7.
REQ-043 Case 6: start held high through FINISH -> second transmission begins one cycle after IDLE is reached.
